// File: rtl/writeback_arbiter_pkg.sv
// Shared types and constants for the writeback arbiter and its result queue.
package writeback_arbiter_pkg;

  localparam int REG_ADDR_W  = 5;
  localparam int NUM_REGS    = 32;
  // Widest result the queue entry can carry; modules use the low DATA_WIDTH bits.
  localparam int WB_DATA_MAX = 64;

  typedef logic [REG_ADDR_W-1:0] reg_addr_t;

  // One queued long-latency result; valid drops when the entry is killed or popped.
  typedef struct packed {
    logic                   valid;
    reg_addr_t              rd;
    logic [WB_DATA_MAX-1:0] data;
  } wb_entry_t;

  // Which source owns the register-file write port this cycle.
  typedef enum logic [1:0] {
    SRC_NONE,
    SRC_ALU,
    SRC_FIFO
  } wb_src_e;

  // One-hot of a destination register; r0 is hardwired and never tracked.
  function automatic logic [NUM_REGS-1:0] rd_onehot(input reg_addr_t rd);
    logic [NUM_REGS-1:0] m;
    m = '0;
    if (rd != '0) m[rd] = 1'b1;
    return m;
  endfunction

endpackage

// File: rtl/writeback_arbiter_if.sv
// Execution-unit side bundle of the writeback arbiter: ALU and long-latency
// result ports in, register-file write port and pending-register mask out.
interface writeback_arbiter_if
  import writeback_arbiter_pkg::*;
#(
  parameter int DATA_WIDTH = 32
);

  logic                  aluValid;
  reg_addr_t             aluRd;
  logic [DATA_WIDTH-1:0] aluData;

  logic                  lsuValid;
  logic                  lsuReady;
  reg_addr_t             lsuRd;
  logic [DATA_WIDTH-1:0] lsuData;

  logic                  regWrite;
  reg_addr_t             writeRegister;
  logic [DATA_WIDTH-1:0] writeData;
  logic [NUM_REGS-1:0]   pendingMask;

  // Producer side (execution units and register file hookup).
  modport master (
    output aluValid, aluRd, aluData, lsuValid, lsuRd, lsuData,
    input  lsuReady, regWrite, writeRegister, writeData, pendingMask
  );

  // Arbiter side.
  modport slave (
    input  aluValid, aluRd, aluData, lsuValid, lsuRd, lsuData,
    output lsuReady, regWrite, writeRegister, writeData, pendingMask
  );

endinterface

// File: rtl/writeback_arbiter_wb_fifo.sv
// In-order queue of long-latency results. Entries whose destination is
// overwritten by a younger ALU result are killed in place: they still pop in
// order but are no longer live, and drop out of the live register mask.
module wb_fifo
  import writeback_arbiter_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  push,
  input  reg_addr_t             push_rd,
  input  logic [DATA_WIDTH-1:0] push_data,
  input  logic                  pop,
  input  logic                  kill_en,
  input  reg_addr_t             kill_rd,
  output logic                  full,
  output logic                  empty,
  output logic                  head_live,
  output reg_addr_t             head_rd,
  output logic [DATA_WIDTH-1:0] head_data,
  output logic [NUM_REGS-1:0]   live_mask
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  typedef logic [PTR_W-1:0] ptr_t;
  typedef logic [CNT_W-1:0] cnt_t;

  localparam cnt_t DEPTH_C = cnt_t'(DEPTH);

  wb_entry_t           mem   [DEPTH];
  wb_entry_t           mem_n [DEPTH];
  ptr_t                wr_ptr, wr_ptr_n;
  ptr_t                rd_ptr, rd_ptr_n;
  cnt_t                count, count_n;
  logic [NUM_REGS-1:0] live_mask_n;
  logic                push_ok, pop_ok;

  assign full    = (count == DEPTH_C);
  assign empty   = (count == '0);
  assign push_ok = push && !full;
  assign pop_ok  = pop && !empty;

  assign head_live = mem[rd_ptr].valid;
  assign head_rd   = mem[rd_ptr].rd;
  assign head_data = mem[rd_ptr].data[DATA_WIDTH-1:0];

  // Next queue state: pop, push, then kill so a same-cycle push is killed too.
  always_comb begin
    // NOTE: every output of this block gets a default first, so no path leaves
    // a variable unassigned and no latch is inferred; blocking '=' is correct
    // here because later statements must see earlier updates within the cycle.
    mem_n       = mem;
    wr_ptr_n    = wr_ptr;
    rd_ptr_n    = rd_ptr;
    count_n     = count;
    live_mask_n = '0;

    if (pop_ok) begin
      mem_n[rd_ptr].valid = 1'b0;
      rd_ptr_n            = rd_ptr + 1'b1;
    end

    if (push_ok) begin
      mem_n[wr_ptr].valid                  = 1'b1;
      mem_n[wr_ptr].rd                     = push_rd;
      mem_n[wr_ptr].data                   = '0;
      mem_n[wr_ptr].data[DATA_WIDTH-1:0]   = push_data;
      wr_ptr_n                             = wr_ptr + 1'b1;
    end

    if (kill_en) begin
      for (int i = 0; i < DEPTH; i++) begin
        if (mem_n[i].rd == kill_rd) mem_n[i].valid = 1'b0;
      end
    end

    case ({push_ok, pop_ok})
      2'b10:   count_n = count + 1'b1;
      2'b01:   count_n = count - 1'b1;
      default: count_n = count;
    endcase

    for (int i = 0; i < DEPTH; i++) begin
      if (mem_n[i].valid) live_mask_n = live_mask_n | rd_onehot(mem_n[i].rd);
    end
  end

  // Queue state register with synchronous reset.
  always_ff @(posedge clk) begin
    // NOTE: only the valid bits of the storage array are reset; rd/data are
    // don't-care while invalid, which keeps the array free of reset muxes.
    if (rst) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      live_mask <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i].valid <= 1'b0;
    end else begin
      wr_ptr    <= wr_ptr_n;
      rd_ptr    <= rd_ptr_n;
      count     <= count_n;
      live_mask <= live_mask_n;
      mem       <= mem_n;
    end
  end

endmodule

// File: rtl/writeback_arbiter.sv
// Writeback arbiter: merges the never-stalled ALU result stream with queued
// long-latency results onto the single register-file write port. The ALU
// always wins; the queue drains in order during ALU-idle cycles.
module writeback_arbiter
  import writeback_arbiter_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int FIFO_DEPTH = 2
) (
  input logic                clk,
  input logic                rst,
  writeback_arbiter_if.slave bus
);

  logic                  lsu_ready;
  logic                  push, pop, kill_en;
  logic                  fifo_full, fifo_empty;
  logic                  head_live;
  reg_addr_t             head_rd;
  logic [DATA_WIDTH-1:0] head_data;
  logic [NUM_REGS-1:0]   live_mask;

  wb_src_e               src;
  logic                  reg_write_n, reg_write_q;
  reg_addr_t             write_register_n, write_register_q;
  logic [DATA_WIDTH-1:0] write_data_n, write_data_q;

  // A pop in this cycle does not open a slot until the next one.
  assign lsu_ready = !fifo_full && !rst;
  assign push      = bus.lsuValid && lsu_ready;
  assign pop       = !bus.aluValid && !fifo_empty;
  // The ALU result is younger than anything queued for the same register.
  assign kill_en   = bus.aluValid && (bus.aluRd != '0);

  wb_fifo #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (push),
    .push_rd   (bus.lsuRd),
    .push_data (bus.lsuData),
    .pop       (pop),
    .kill_en   (kill_en),
    .kill_rd   (bus.aluRd),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .head_live (head_live),
    .head_rd   (head_rd),
    .head_data (head_data),
    .live_mask (live_mask)
  );

  // Pick the write source; dead entries and r0 targets write nothing.
  always_comb begin
    src              = SRC_NONE;
    reg_write_n      = 1'b0;
    write_register_n = '0;
    write_data_n     = '0;

    if (bus.aluValid)     src = SRC_ALU;
    else if (!fifo_empty) src = SRC_FIFO;

    unique case (src)
      SRC_ALU: begin
        if (bus.aluRd != '0) begin
          reg_write_n      = 1'b1;
          write_register_n = bus.aluRd;
          write_data_n     = bus.aluData;
        end
      end
      SRC_FIFO: begin
        if (head_live && (head_rd != '0)) begin
          reg_write_n      = 1'b1;
          write_register_n = head_rd;
          write_data_n     = head_data;
        end
      end
      default: ;
    endcase
  end

  // Register-file write port register.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking '<=' so every flop samples the
    // pre-edge values and the simulation order of always blocks cannot matter.
    if (rst) begin
      reg_write_q      <= 1'b0;
      write_register_q <= '0;
      write_data_q     <= '0;
    end else begin
      reg_write_q      <= reg_write_n;
      write_register_q <= write_register_n;
      write_data_q     <= write_data_n;
    end
  end

  assign bus.lsuReady      = lsu_ready;
  assign bus.regWrite      = reg_write_q;
  assign bus.writeRegister = write_register_q;
  assign bus.writeData     = write_data_q;
  assign bus.pendingMask   = live_mask;

endmodule

// File: tb/tb_writeback_arbiter.sv
// Directed bench for writeback_arbiter: a cycle-by-cycle vector table with
// hand-computed expectations, followed by a back-pressure/ordering sequence.
module tb_writeback_arbiter;

  logic clk = 1'b0;
  logic rst = 1'b1;

  always #5 clk = ~clk;

  writeback_arbiter_if #(.DATA_WIDTH(32)) bus_if ();

  writeback_arbiter #(
    .DATA_WIDTH (32),
    .FIFO_DEPTH (2)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus_if)
  );

  // One row = inputs held for one cycle, lsuReady expected in that cycle,
  // and the registered outputs expected in the following cycle.
  typedef struct {
    logic        rst;
    logic        av;
    logic [4:0]  ar;
    logic [31:0] ad;
    logic        lv;
    logic [4:0]  lr;
    logic [31:0] ld;
    logic        er;
    logic        ew;
    logic [4:0]  ewr;
    logic [31:0] ewd;
    logic [31:0] em;
  } vec_t;

  localparam int NV = 27;
  vec_t vecs [NV];

  int n_checks = 0;
  int n_errors = 0;
  int wr_log[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic av, input logic [4:0] ar, input logic [31:0] ad,
                       input logic lv, input logic [4:0] lr, input logic [31:0] ld);
    bus_if.aluValid = av;
    bus_if.aluRd    = ar;
    bus_if.aluData  = ad;
    bus_if.lsuValid = lv;
    bus_if.lsuRd    = lr;
    bus_if.lsuData  = ld;
  endtask

  // Advance one clock and log any register-file write seen after the edge.
  task automatic cycle();
    @(posedge clk);
    #1;
    if (bus_if.regWrite === 1'b1) wr_log.push_back(int'(bus_if.writeRegister));
  endtask

  task automatic check_outputs(input string tag, input logic ew, input logic [4:0] ewr,
                               input logic [31:0] ewd, input logic [31:0] em);
    check({tag, " regWrite"}, 32'(bus_if.regWrite), 32'(ew));
    check({tag, " writeRegister"}, 32'(bus_if.writeRegister), 32'(ewr));
    check({tag, " writeData"}, bus_if.writeData, ewd);
    check({tag, " pendingMask"}, bus_if.pendingMask, em);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int exp_log[$];
    logic accepted;

    //                rst av ar  ad            lv lr  ld        er ew ewr ewd           em
    vecs[0]  = '{1'b0, 1, 5,  32'hDEADBEEF,  0, 0,  32'h0,    1, 1, 5,  32'hDEADBEEF, 32'h0};
    vecs[1]  = '{1'b0, 1, 9,  32'h99,        1, 7,  32'h11,   1, 1, 9,  32'h99,       32'h80};
    vecs[2]  = '{1'b0, 1, 9,  32'h9A,        0, 0,  32'h0,    1, 1, 9,  32'h9A,       32'h80};
    vecs[3]  = '{1'b0, 0, 0,  32'h0,         0, 0,  32'h0,    1, 1, 7,  32'h11,       32'h0};
    vecs[4]  = '{1'b0, 1, 1,  32'h01,        1, 3,  32'h33,   1, 1, 1,  32'h01,       32'h08};
    vecs[5]  = '{1'b0, 1, 2,  32'h02,        1, 4,  32'h44,   1, 1, 2,  32'h02,       32'h18};
    vecs[6]  = '{1'b0, 1, 10, 32'h0A,        1, 6,  32'h66,   0, 1, 10, 32'h0A,       32'h18};
    vecs[7]  = '{1'b0, 0, 0,  32'h0,         1, 6,  32'h66,   0, 1, 3,  32'h33,       32'h10};
    vecs[8]  = '{1'b0, 0, 0,  32'h0,         1, 6,  32'h66,   1, 1, 4,  32'h44,       32'h40};
    vecs[9]  = '{1'b0, 0, 0,  32'h0,         0, 0,  32'h0,    1, 1, 6,  32'h66,       32'h0};
    vecs[10] = '{1'b0, 0, 0,  32'h0,         1, 8,  32'h88,   1, 0, 0,  32'h0,        32'h100};
    vecs[11] = '{1'b0, 1, 8,  32'hAA,        0, 0,  32'h0,    1, 1, 8,  32'hAA,       32'h0};
    vecs[12] = '{1'b0, 0, 0,  32'h0,         0, 0,  32'h0,    1, 0, 0,  32'h0,        32'h0};
    vecs[13] = '{1'b0, 1, 12, 32'hDD,        1, 12, 32'hCC,   1, 1, 12, 32'hDD,       32'h0};
    vecs[14] = '{1'b0, 0, 0,  32'h0,         0, 0,  32'h0,    1, 0, 0,  32'h0,        32'h0};
    vecs[15] = '{1'b0, 1, 0,  32'h55,        1, 0,  32'h77,   1, 0, 0,  32'h0,        32'h0};
    vecs[16] = '{1'b0, 0, 0,  32'h0,         0, 0,  32'h0,    1, 0, 0,  32'h0,        32'h0};
    vecs[17] = '{1'b0, 0, 0,  32'h0,         0, 0,  32'h0,    1, 0, 0,  32'h0,        32'h0};
    vecs[18] = '{1'b0, 1, 1,  32'h01,        1, 11, 32'hB1,   1, 1, 1,  32'h01,       32'h800};
    vecs[19] = '{1'b0, 1, 11, 32'hE1,        1, 13, 32'hD1,   1, 1, 11, 32'hE1,       32'h2000};
    vecs[20] = '{1'b0, 0, 0,  32'h0,         0, 0,  32'h0,    0, 0, 0,  32'h0,        32'h2000};
    vecs[21] = '{1'b0, 0, 0,  32'h0,         0, 0,  32'h0,    1, 1, 13, 32'hD1,       32'h0};
    vecs[22] = '{1'b0, 1, 15, 32'hF5,        1, 14, 32'hE4,   1, 1, 15, 32'hF5,       32'h4000};
    vecs[23] = '{1'b0, 1, 17, 32'h17,        1, 16, 32'h10,   1, 1, 17, 32'h17,       32'h14000};
    vecs[24] = '{1'b1, 1, 18, 32'h18,        1, 19, 32'h19,   0, 0, 0,  32'h0,        32'h0};
    vecs[25] = '{1'b0, 0, 0,  32'h0,         0, 0,  32'h0,    1, 0, 0,  32'h0,        32'h0};
    vecs[26] = '{1'b0, 0, 0,  32'h0,         0, 0,  32'h0,    1, 0, 0,  32'h0,        32'h0};

    // Reset with an offer pending: it must be ignored.
    rst = 1'b1;
    drive(1'b1, 5'd3, 32'h3, 1'b1, 5'd2, 32'h2);
    cycle();
    cycle();
    check("reset lsuReady", 32'(bus_if.lsuReady), 32'h0);
    check_outputs("reset", 1'b0, 5'd0, 32'h0, 32'h0);

    rst = 1'b0;
    drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
    #1;
    check("post-reset lsuReady", 32'(bus_if.lsuReady), 32'h1);
    cycle();
    check_outputs("post-reset", 1'b0, 5'd0, 32'h0, 32'h0);

    for (int i = 0; i < NV; i++) begin
      rst = vecs[i].rst;
      drive(vecs[i].av, vecs[i].ar, vecs[i].ad, vecs[i].lv, vecs[i].lr, vecs[i].ld);
      #1;
      check($sformatf("row%0d lsuReady", i), 32'(bus_if.lsuReady), 32'(vecs[i].er));
      cycle();
      check_outputs($sformatf("row%0d", i), vecs[i].ew, vecs[i].ewr, vecs[i].ewd, vecs[i].em);
    end

    // Back-pressure: fill the queue under a busy ALU, hold a third offer,
    // then let the queue drain and confirm write order.
    wr_log.delete();
    drive(1'b1, 5'd20, 32'h20, 1'b1, 5'd3, 32'h3);
    cycle();
    drive(1'b1, 5'd21, 32'h21, 1'b1, 5'd4, 32'h4);
    cycle();
    drive(1'b1, 5'd22, 32'h22, 1'b1, 5'd5, 32'h5);
    for (int i = 0; i < 3; i++) begin
      #1;
      check($sformatf("full hold %0d lsuReady", i), 32'(bus_if.lsuReady), 32'h0);
      cycle();
    end
    check("full pendingMask", bus_if.pendingMask, 32'h18);

    bus_if.aluValid = 1'b0;
    accepted = 1'b0;
    for (int i = 0; i < 8 && !accepted; i++) begin
      #1;
      if (bus_if.lsuReady === 1'b1) accepted = 1'b1;
      cycle();
    end
    check("third offer accepted", 32'(accepted), 32'h1);
    drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
    for (int i = 0; i < 4; i++) cycle();

    exp_log = '{20, 21, 22, 22, 22, 3, 4, 5};
    check("drain write count", 32'(wr_log.size()), 32'(exp_log.size()));
    for (int i = 0; i < exp_log.size(); i++) begin
      check($sformatf("drain write %0d rd", i),
            (i < wr_log.size()) ? 32'(wr_log[i]) : 32'hFFFF_FFFF, 32'(exp_log[i]));
    end
    check("drained pendingMask", bus_if.pendingMask, 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/writeback_arbiter.md
WRITEBACK_ARBITER -- requirements
Module: writeback_arbiter

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, width of result data.
REQ-002 SHALL have parameter FIFO_DEPTH, default 2, number of queued long-latency results (power of two, >=2).
REQ-003 SHALL have one clock; reset is synchronous and active-high: clk  in  1  rising-edge clock; rst  in  1  synchronous active-high reset.
REQ-004 SHALL have port aluValid  in  1  single-cycle result present this cycle (never stalled).
REQ-005 SHALL have port aluRd  in  5  destination register of ALU result.
REQ-006 SHALL have port aluData  in  DATA_WIDTH  ALU result.
REQ-007 SHALL have port lsuValid  in  1  long-latency (load/mul/div) result offered.
REQ-008 SHALL have port lsuReady  out  1  queue accepts result; transfer when lsuValid && lsuReady.
REQ-009 SHALL have port lsuRd  in  5  destination register of long-latency result.
REQ-010 SHALL have port lsuData  in  DATA_WIDTH  long-latency result.
REQ-011 SHALL have port regWrite  out  1  register-file write enable (registered).
REQ-012 SHALL have port writeRegister  out  5  register-file write address (registered).
REQ-013 SHALL have port writeData  out  DATA_WIDTH  register-file write data (registered).
REQ-014 SHALL have port pendingMask  out  32  bit r set while a live queued result targets register r.

Function
REQ-015 ALU result with aluValid in cycle N SHALL appear as regWrite=1, writeRegister=aluRd, writeData=aluData in cycle N+1.
REQ-016 ALU SHALL have absolute priority; queue drains only in cycles with aluValid=0.
REQ-017 Accepted long-latency result SHALL enter the FIFO; earliest regWrite for it is cycle N+2 after acceptance cycle N.
REQ-018 FIFO SHALL drain strictly in acceptance order, one entry per non-ALU cycle.
REQ-019 lsuReady SHALL equal (count < FIFO_DEPTH) && !rst; a pop in the same cycle does not raise lsuReady.
REQ-020 Push and pop in the same cycle SHALL both occur; count unchanged.
REQ-021 Any result with rd=0 SHALL produce regWrite=0 (entry still consumed/popped).
REQ-022 aluValid with aluRd=r!=0 SHALL kill every queued entry with rd=r, including an entry accepted in the same cycle (ALU result is younger).
REQ-023 Killed entry SHALL still pop in order but produce regWrite=0; its pendingMask bit clears the cycle after the kill.
REQ-024 pendingMask SHALL be the OR of one-hot rd of live entries; bit 0 always 0; registered.
REQ-025 When regWrite=0, writeRegister and writeData SHALL be 0.
REQ-026 FIFO pointers SHALL wrap modulo FIFO_DEPTH; count SHALL never exceed FIFO_DEPTH nor underflow.

Reset
REQ-027 While rst=1: regWrite=0, writeRegister=0, writeData=0, pendingMask=0, lsuReady=0, FIFO emptied, pushes ignored.
REQ-028 Reset asserted mid-drain SHALL discard all queued entries; no write issues for them after reset.
REQ-029 First cycle after rst deasserts, lsuReady SHALL be 1.

Structure
REQ-030 Shared package SHALL hold REG_ADDR_W=5, NUM_REGS=32 and typedef wb_entry_t {valid, rd, data}.
REQ-031 Queue SHALL be sub-module wb_fifo (FIFO with per-entry kill-by-rd input); arbiter logic and output registers stay in writeback_arbiter.
REQ-032 Output regWrite/writeRegister/writeData SHALL connect directly to the register file write port.

Verification
REQ-033 aluValid=1, aluRd=5, aluData=0xDEADBEEF at cycle 10 -> cycle 11 regWrite=1, writeRegister=5, writeData=0xDEADBEEF.
REQ-034 lsu rd=7 data=0x11 accepted cycle 3, aluValid=1 cycles 4-5 (rd=9) -> rd=9 writes cycles 5,6; rd=7 write cycle 7; pendingMask[7]=1 cycles 4-6.
REQ-035 Two lsu pushes (rd=3,rd=4) with ALU busy -> lsuReady=0 while full; third offer held until pop; writes order 3 then 4.
REQ-036 lsu rd=8 queued, then aluValid rd=8 data=0xAA -> single write of 0xAA to r8; queued entry pops with regWrite=0; pendingMask[8] clears.
REQ-037 aluRd=0 and lsu rd=0 results -> regWrite never asserted; FIFO still empties.
REQ-038 rst=1 with FIFO full -> next cycle all outputs 0, lsuReady=0; after release lsuReady=1, no stale writes.
